// File: rtl/lsu.sv
// Load/store unit: one memory op at a time on a valid/ready data port, with
// byte-lane steering for stores and sign/zero extraction for loads.
module lsu #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              lsu_en,
    input  logic              op_valid,
    input  logic              op_store,
    input  logic [2:0]        op_funct3,
    input  logic [ADDR_W-1:0] op_addr,
    input  logic [XLEN-1:0]   op_wdata,
    input  logic [4:0]        op_rd,
    output logic              op_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              ld_valid,
    output logic [XLEN-1:0]   ld_data,
    output logic [4:0]        ld_rd,
    output logic              misalign
);

    // state | meaning
    // IDLE  | ready for a new op
    // REQ   | mem_req asserted, waiting for mem_ready
    // WAIT  | load accepted by memory, waiting for read data
    // DRAIN | flushed load still outstanding; response is discarded
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [2:0]      funct3_q;
    logic [1:0]      off_q;
    logic [4:0]      rd_q;
    logic            store_q;

    logic            size_b;
    logic            size_h;
    logic            accept;
    logic            aligned;
    logic            issue;
    logic            ld_fire;
    logic [3:0]      lane_strb;
    logic [XLEN-1:0] lane_data;
    logic [XLEN-1:0] rshift;
    logic [XLEN-1:0] ld_ext;

    // funct3[1:0] encodes the access size; unused encodings behave as word
    assign size_b  = (op_funct3[1:0] == 2'b00);
    assign size_h  = (op_funct3[1:0] == 2'b01);
    assign accept  = (state == IDLE) && op_valid && lsu_en && !flush;
    assign aligned = size_b
                  || (size_h && !op_addr[0])
                  || (!size_b && !size_h && (op_addr[1:0] == 2'b00));
    assign issue   = accept && aligned;

    assign op_ready = (state == IDLE);
    assign mem_req  = (state == REQ);
    assign mem_we   = mem_req && store_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ld_fire   = 1'b0;
        case (state)
            IDLE: begin
                if (issue) state_nxt = REQ;
            end
            REQ: begin
                // a store already handed to memory is committed even under flush
                if (mem_ready) begin
                    if (store_q)    state_nxt = IDLE;
                    else if (flush) state_nxt = DRAIN;
                    else            state_nxt = WAIT;
                end else if (flush) begin
                    state_nxt = IDLE;
                end
            end
            WAIT: begin
                if (flush) begin
                    state_nxt = mem_rvalid ? IDLE : DRAIN;
                end else if (mem_rvalid) begin
                    state_nxt = IDLE;
                    ld_fire   = 1'b1;
                end
            end
            DRAIN: begin
                if (mem_rvalid) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        lane_strb = 4'b1111;
        lane_data = op_wdata;
        if (size_b) begin
            lane_strb = 4'b0001 << op_addr[1:0];
            lane_data = {4{op_wdata[7:0]}};
        end else if (size_h) begin
            lane_strb = 4'b0011 << op_addr[1:0];
            lane_data = {2{op_wdata[15:0]}};
        end
    end

    assign rshift = mem_rdata >> {off_q, 3'b000};

    always_comb begin
        case (funct3_q)
            3'b000:  ld_ext = {{(XLEN-8){rshift[7]}}, rshift[7:0]};
            3'b100:  ld_ext = {{(XLEN-8){1'b0}}, rshift[7:0]};
            3'b001:  ld_ext = {{(XLEN-16){rshift[15]}}, rshift[15:0]};
            3'b101:  ld_ext = {{(XLEN-16){1'b0}}, rshift[15:0]};
            default: ld_ext = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= 4'b0000;
            store_q   <= 1'b0;
            funct3_q  <= 3'b000;
            off_q     <= 2'b00;
            rd_q      <= 5'd0;
            ld_valid  <= 1'b0;
            ld_data   <= '0;
            ld_rd     <= 5'd0;
            misalign  <= 1'b0;
        end else begin
            misalign <= accept && !aligned;
            ld_valid <= ld_fire;
            if (issue) begin
                mem_addr  <= {op_addr[ADDR_W-1:2], 2'b00};
                mem_wstrb <= op_store ? lane_strb : 4'b0000;
                mem_wdata <= op_store ? lane_data : '0;
                store_q   <= op_store;
                funct3_q  <= op_funct3;
                off_q     <= op_addr[1:0];
                rd_q      <= op_rd;
            end
            if (ld_fire) begin
                ld_data <= ld_ext;
                ld_rd   <= rd_q;
            end
        end
    end

endmodule
